// File: rtl/whack_scorer.sv
// whack_scorer: per-player scoring engine for the whack-a-mole game.
// Brings the raw switch levels into clk_sys time, detects toggles in both
// directions, and classifies each toggle against the live mole map as a hit
// or a miss. Keeps a saturating score and a hit streak. A hole that has
// already scored stays consumed until its mole goes dark.
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset
//   enable  game running; toggles are ignored while low
//   clear   synchronous clear of score, streak and consumed mask
//   sw      raw switch levels, asynchronous to clk
//   ledr    mole-present map, synchronous to clk
//   point   one-cycle pulse, at least one hit this cycle
//   miss    one-cycle pulse, at least one miss this cycle
//   score   current score, clamped to [0, 2^SCORE_W-1]
//   streak  hits since the last miss, saturating
module whack_scorer #(
   parameter int N_HOLES = 18,
   parameter int SCORE_W = 10,
   parameter int PENALTY = 1,
   parameter int HIT_PTS = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               clear,
   input  logic [N_HOLES-1:0] sw,
   input  logic [N_HOLES-1:0] ledr,
   output logic               point,
   output logic               miss,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] streak
);

   localparam int CW = $clog2(N_HOLES + 1);
   localparam int EW = SCORE_W + $clog2(N_HOLES) + 2;
   localparam logic signed [EW-1:0] MAX_S = EW'((1 << SCORE_W) - 1);

   logic [N_HOLES-1:0] sw_s1, sw_s2, sw_prev, consumed;
   logic [N_HOLES-1:0] sw_edge, hit, miss_v;
   logic [1:0]         warm;
   logic [CW-1:0]      nh, nm;
   logic signed [EW-1:0] score_sum, streak_sum;
   logic [SCORE_W-1:0] score_next, streak_next;

   always_comb begin
      sw_edge = sw_s2 ^ sw_prev;
      hit     = enable ? (sw_edge & ledr & ~consumed) : '0;
      miss_v  = enable ? (sw_edge & ~ledr) : '0;

      nh = '0;
      nm = '0;
      for (int j = 0; j < N_HOLES; j++) begin
         nh = nh + CW'(hit[j]);
         nm = nm + CW'(miss_v[j]);
      end

      // Wide enough that neither the add nor the subtract can wrap before clamping.
      score_sum = EW'(score) + EW'(nh) * EW'(HIT_PTS) - EW'(nm) * EW'(PENALTY);
      if (score_sum < 0)
         score_next = '0;
      else if (score_sum > MAX_S)
         score_next = '1;
      else
         score_next = score_sum[SCORE_W-1:0];

      streak_sum = EW'(streak) + EW'(nh);
      if (nm != '0)
         streak_next = '0;
      else if (streak_sum > MAX_S)
         streak_next = '1;
      else
         streak_next = streak_sum[SCORE_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_s1    <= '0;
         sw_s2    <= '0;
         sw_prev  <= '0;
         warm     <= '0;
         consumed <= '0;
         point    <= 1'b0;
         miss     <= 1'b0;
         score    <= '0;
         streak   <= '0;
      end else begin
         sw_s1 <= sw;
         sw_s2 <= sw_s1;
         // Until the synchroniser has filled, track sw_s1 so that switches
         // already high at reset release do not appear as toggles.
         if (warm != 2'd2) begin
            sw_prev <= sw_s1;
            warm    <= warm + 2'd1;
         end else begin
            sw_prev <= sw_s2;
         end

         if (clear) begin
            consumed <= '0;
            score    <= '0;
            streak   <= '0;
            point    <= 1'b0;
            miss     <= 1'b0;
         end else begin
            consumed <= (consumed | hit) & ledr;
            score    <= score_next;
            streak   <= streak_next;
            point    <= |hit;
            miss     <= |miss_v;
         end
      end
   end

endmodule

// File: tb/tb_whack_scorer.sv
module tb_whack_scorer;

   localparam int N = 18;

   logic         clk, rst, enable, clear;
   logic [N-1:0] sw, ledr;

   logic         point_a, miss_a, point_b, miss_b, point_c, miss_c;
   logic [9:0]   score_a, streak_a, score_b, streak_b;
   logic [3:0]   score_c, streak_c;

   // a: default build, b: penalties disabled, c: 4-bit counters
   whack_scorer #(.N_HOLES(N), .SCORE_W(10), .PENALTY(1), .HIT_PTS(1)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear), .sw(sw), .ledr(ledr),
      .point(point_a), .miss(miss_a), .score(score_a), .streak(streak_a));
   whack_scorer #(.N_HOLES(N), .SCORE_W(10), .PENALTY(0), .HIT_PTS(1)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear), .sw(sw), .ledr(ledr),
      .point(point_b), .miss(miss_b), .score(score_b), .streak(streak_b));
   whack_scorer #(.N_HOLES(N), .SCORE_W(4), .PENALTY(1), .HIT_PTS(1)) dut_c (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear), .sw(sw), .ledr(ledr),
      .point(point_c), .miss(miss_c), .score(score_c), .streak(streak_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total, bad;

   // reference model state, one slot per build
   logic [N-1:0] samp[$];
   int           m_score[3], m_streak[3];
   bit           m_point[3], m_miss[3];
   logic [N-1:0] m_cons[3];
   int           pen[3] = '{1, 0, 1};
   int           mx[3]  = '{1023, 1023, 15};

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      samp.delete();
      for (int c = 0; c < 3; c++) begin
         m_score[c] = 0; m_streak[c] = 0;
         m_point[c] = 0; m_miss[c] = 0;
         m_cons[c] = '0;
      end
   endtask

   // A toggle seen at input sample k is judged at sample k+2; the first
   // three samples after release only establish the baseline level.
   task automatic model_edge();
      logic [N-1:0] e;
      int n, nh, nm, s;
      samp.push_back(sw);
      n = samp.size() - 1;
      e = (n >= 3) ? (samp[n-2] ^ samp[n-3]) : '0;
      for (int c = 0; c < 3; c++) begin
         if (clear) begin
            m_score[c] = 0; m_streak[c] = 0;
            m_point[c] = 0; m_miss[c] = 0;
            m_cons[c] = '0;
         end else begin
            nh = 0; nm = 0;
            for (int j = 0; j < N; j++) begin
               if (enable && e[j]) begin
                  if (!ledr[j]) nm++;
                  else if (!m_cons[c][j]) begin
                     nh++;
                     m_cons[c][j] = 1'b1;
                  end
               end
               if (!ledr[j]) m_cons[c][j] = 1'b0;
            end
            s = m_score[c] + nh - nm * pen[c];
            m_score[c]  = (s < 0) ? 0 : (s > mx[c]) ? mx[c] : s;
            m_streak[c] = (nm > 0) ? 0 :
                          (m_streak[c] + nh > mx[c]) ? mx[c] : m_streak[c] + nh;
            m_point[c] = (nh > 0);
            m_miss[c]  = (nm > 0);
         end
      end
   endtask

   task automatic check_all();
      chk("a.point",  point_a,  m_point[0]);
      chk("a.miss",   miss_a,   m_miss[0]);
      chk("a.score",  score_a,  m_score[0]);
      chk("a.streak", streak_a, m_streak[0]);
      chk("b.point",  point_b,  m_point[1]);
      chk("b.miss",   miss_b,   m_miss[1]);
      chk("b.score",  score_b,  m_score[1]);
      chk("b.streak", streak_b, m_streak[1]);
      chk("c.point",  point_c,  m_point[2]);
      chk("c.miss",   miss_c,   m_miss[2]);
      chk("c.score",  score_c,  m_score[2]);
      chk("c.streak", streak_c, m_streak[2]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic ticks(int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; enable = 1'b0; clear = 1'b0; sw = '0; ledr = '0;
      model_reset();
      #1;
      chk("rst.point", point_a, 0);
      chk("rst.score", score_a, 0);
      chk("rst.streak", streak_a, 0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      model_reset();
      ticks(4);

      // 1: single hit, 3-edge latency, one-cycle pulse
      enable = 1'b1;
      ledr = 18'h00008;
      sw[3] = 1'b1;
      tick(); chk("t1.e0.point", point_a, 0);
      tick(); chk("t1.e1.point", point_a, 0);
      tick(); chk("t1.point", point_a, 1);
      chk("t1.score", score_a, 1); chk("t1.streak", streak_a, 1); chk("t1.miss", miss_a, 0);
      tick(); chk("t1.pulse_end", point_a, 0);

      // 2: consumed hole ignores toggle back; relight re-arms
      sw[3] = 1'b0;
      ticks(4);
      chk("t2.consumed.score", score_a, 1); chk("t2.consumed.miss", miss_a, 0);
      ledr[3] = 1'b0; tick();
      ledr[3] = 1'b1; tick();
      sw[3] = 1'b1;
      ticks(3);
      chk("t2.rearm.score", score_a, 2);

      // 3: two hits and a miss together
      ledr = 18'h00005;
      sw = sw ^ 18'h00085;
      ticks(3);
      chk("t3.point", point_a, 1); chk("t3.miss", miss_a, 1);
      chk("t3.score", score_a, 3); chk("t3.streak", streak_a, 0);
      chk("t3.b.score", score_b, 4);
      ticks(2);

      // 4: floor at zero; no-penalty build keeps score but loses streak
      clear = 1'b1; tick(); clear = 1'b0;
      ledr = '0;
      sw[5] = ~sw[5];
      ticks(3);
      chk("t4.miss", miss_a, 1); chk("t4.floor", score_a, 0);
      ledr = 18'h00040; sw[6] = ~sw[6]; ticks(3);
      ledr = '0;        sw[6] = ~sw[6]; ticks(3);
      chk("t4.a.score", score_a, 0);
      chk("t4.b.score", score_b, 1); chk("t4.b.streak", streak_b, 0);

      // 5: saturation on the 4-bit build
      ledr = '1;
      for (int i = 0; i < 16; i++) begin
         sw[i] = ~sw[i];
         tick();
      end
      ticks(3);
      chk("t5.c.score", score_c, 15); chk("t5.c.streak", streak_c, 15);
      chk("t5.a.score", score_a, 16);
      sw[16] = ~sw[16];
      ticks(3);
      chk("t5.c.sat.point", point_c, 1);
      chk("t5.c.sat.score", score_c, 15); chk("t5.c.sat.streak", streak_c, 15);
      chk("t5.a.score2", score_a, 17);

      // 6: disabled toggle never replays
      ledr = '0; tick();
      ledr = 18'h00002; enable = 1'b0;
      sw[1] = ~sw[1];
      ticks(5);
      enable = 1'b1;
      ticks(4);
      chk("t6.noreplay.score", score_a, 17);

      // 6: clear overrides a hit in the same cycle
      ledr = 18'h00004; sw[2] = ~sw[2];
      ticks(2);
      clear = 1'b1; tick();
      chk("t6.clr.point", point_a, 0); chk("t6.clr.score", score_a, 0);
      chk("t6.clr.streak", streak_a, 0);
      clear = 1'b0; tick();
      chk("t6.clr.after", point_a, 0);

      // 6: async reset mid-pulse
      ledr = 18'h00010; sw[4] = ~sw[4];
      ticks(3);
      chk("t6.pre_rst.point", point_a, 1);
      #2 rst = 1'b1;
      #1;
      chk("t6.rst.point", point_a, 0); chk("t6.rst.score", score_a, 0);
      chk("t6.rst.streak", streak_a, 0); chk("t6.rst.c.score", score_c, 0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      model_reset();
      ticks(4);

      // randomized play against the model
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(3) == 0) sw[$urandom_range(N-1)] ^= 1'b1;
         if ($urandom_range(7) == 0) sw[$urandom_range(N-1)] ^= 1'b1;
         if ($urandom_range(9) == 0) ledr = N'($urandom);
         enable = ($urandom_range(15) != 0);
         clear  = ($urandom_range(60) == 0);
         tick();
      end
      clear = 1'b0;
      ticks(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
